// File: rtl/mc_control_seq.sv
// Multicycle control sequencer for the i281 datapath: one-hot opcode decode into control word c[24:1].
// Optional build macro CTRL_SINGLE_STEP_EN adds a `step` input that releases IF for one instruction per rising edge.
module mc_control_seq #(
  parameter int OPW      = 23,
  parameter int NFLAGS   = 4,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [OPW+3:0]  opcode_in,
  input  logic [NFLAGS-1:0] flags,
  input  logic            mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [24:1]     c,
  output logic [3:0]      state_o,
  output logic            instr_done,
  output logic            halted,
  output logic            err
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX_ALU = 4'd2, S_EX_ADDR = 4'd3, S_EX_JUMP = 4'd4,
    S_EX_LOAD = 4'd5, S_EX_LOADI = 4'd6, S_EX_MOVE = 4'd7, S_MEM_RD = 4'd8,
    S_MEM_WR = 4'd9, S_WB_ALU = 4'd10, S_WB_LOAD = 4'd11, S_ERR = 4'd15
  } state_t;

  localparam bit              TIMEOUT_EN = (WAIT_MAX != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [22:0]       r_op;
  logic [1:0]        r_rx;
  logic              r_done;
  logic [OPW-1:0]    w_op;
  logic              w_z, w_n, w_take, w_release, w_mem, w_unused;

  assign w_op     = opcode_in[OPW-1:0];
  assign w_z      = flags[0];
  assign w_n      = flags[1];
  assign w_mem    = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_unused = ^{flags, r_op};
  assign w_take   = (w_op[19] & w_z) | (w_op[20] & ~w_z) |
                    (w_op[21] & ~w_z & ~w_n) | (w_op[22] & ~w_n);

`ifdef CTRL_SINGLE_STEP_EN
  logic r_step_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_step_q <= 1'b0;
    else       r_step_q <= step;
  assign w_release = run | (step & ~r_step_q);
`else
  assign w_release = run;
`endif

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;

  // MEM_RD/MEM_WR handshake: the state advances on the edge where mem_ready=1 and
  // holds otherwise; WAIT_MAX consecutive not-ready cycles abort into ERR.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF:       w_next = w_release ? S_ID : S_IF;
      S_ID: begin
        if (!$onehot(w_op))                               w_next = S_ERR;
        else if (w_op[0])                                 w_next = S_IF;
        else if (|w_op[4:1] || w_op[6])                   w_next = S_EX_LOADI;
        else if (w_op[5])                                 w_next = S_EX_MOVE;
        else if (w_op[7] || w_op[9] || w_op[15] || w_op[16] || w_op[17])
                                                          w_next = S_EX_ALU;
        else if (w_op[8] || w_op[10] || w_op[12] || w_op[14])
                                                          w_next = S_EX_ADDR;
        else if (w_op[11] || w_op[13])                    w_next = S_EX_LOAD;
        else if (w_op[18])                                w_next = S_EX_JUMP;
        else if (|w_op[22:19])                            w_next = w_take ? S_EX_JUMP : S_IF;
        else                                              w_next = S_ERR;
      end
      S_EX_ALU:   w_next = r_op[17] ? S_IF : S_WB_ALU;
      S_EX_ADDR:  w_next = r_op[12] ? S_MEM_RD : (r_op[14] ? S_MEM_WR : S_WB_ALU);
      S_EX_LOAD:  w_next = r_op[11] ? S_MEM_RD : S_MEM_WR;
      S_EX_LOADI: w_next = r_op[6] ? S_WB_ALU : S_MEM_WR;
      S_EX_MOVE:  w_next = S_WB_ALU;
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready)                              w_next = (r_state == S_MEM_RD) ? S_WB_LOAD : S_IF;
        else if (TIMEOUT_EN && r_wait == WAIT_LAST) w_next = S_ERR;
        else                                        w_next = r_state;
      end
      S_WB_ALU, S_WB_LOAD, S_EX_JUMP: w_next = S_IF;
      S_ERR:      w_next = S_ERR;
      default:    w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wait <= '0;
      r_op   <= '0;
      r_rx   <= '0;
      r_done <= 1'b0;
    end else begin
      r_wait <= (w_mem && w_next == r_state) ? r_wait + WAIT_W'(1) : '0;
      r_done <= (r_state != S_IF) && (w_next == S_IF);
      if (r_state == S_ID) begin
        r_op <= opcode_in[22:0];
        r_rx <= opcode_in[OPW+3:OPW+2];
      end
    end

  always_comb begin
    c       = '0;
    state_o = r_state;
    halted  = (r_state == S_IF) && !run;
    err     = (r_state == S_ERR);
    case (r_state)
      S_IF: if (run) begin
        c[3] = 1'b1; c[12] = 1'b1; c[16] = 1'b1; c[20] = 1'b1; c[22] = 1'b1;
      end
      S_ID: begin
        c[3] = 1'b1; c[11] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; c[22] = 1'b1;
        c[5:4] = opcode_in[OPW+3:OPW+2];
        c[7:6] = opcode_in[OPW+1:OPW];
      end
      S_EX_JUMP: begin c[2] = 1'b1; c[3] = 1'b1; end
      S_EX_ALU, S_EX_ADDR: begin
        c[14] = 1'b1; c[22] = 1'b1; c[24] = 1'b1;
        c[21] = (r_state == S_EX_ALU);
        c[12] = !(r_op[15] || r_op[16]);
        c[13] = r_op[9] || r_op[10] || r_op[17] || r_op[16];
      end
      S_EX_LOAD:  begin c[12] = 1'b1; c[14] = 1'b1; c[19] = 1'b1; c[22] = 1'b1; c[24] = 1'b1; end
      S_EX_MOVE:  begin
        c[12] = 1'b1; c[14] = 1'b1; c[19] = 1'b1; c[20] = 1'b1; c[22] = 1'b1; c[24] = 1'b1;
      end
      S_EX_LOADI: begin c[12] = 1'b1; c[19] = 1'b1; c[22] = 1'b1; end
      S_MEM_RD:   c[23] = 1'b1;
      S_MEM_WR:   c[17] = 1'b1;
      S_WB_ALU:   begin c[10] = 1'b1; c[9:8] = r_rx; end
      S_WB_LOAD:  begin c[10] = 1'b1; c[18] = 1'b1; c[9:8] = r_rx; end
      default:    c = '0;
    endcase
  end

  assign instr_done = r_done;

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed bench for mc_control_seq: driver pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_mc_control_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [26:0] opcode_in;
  logic [3:0]  flags;
  logic        mem_ready;
  logic [24:1] c;
  logic [3:0]  state_o;
  logic        instr_done, halted, err;

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXA = 4'd2, S_EXD = 4'd3, S_EXJ = 4'd4,
                         S_EXL = 4'd5, S_MRD = 4'd8, S_MWR = 4'd9, S_WBA = 4'd10,
                         S_WBL = 4'd11, S_ERR = 4'd15;
  localparam logic [23:0] C_IF = 24'h288804, C_ID = 24'h204C04;

  int n_checks = 0;
  int n_errors = 0;
  logic [30:0] exp_q[$];
  string       name_q[$];

  mc_control_seq dut (
    .clock(clock), .reset(reset), .run(run), .opcode_in(opcode_in), .flags(flags),
    .mem_ready(mem_ready), .c(c), .state_o(state_o), .instr_done(instr_done),
    .halted(halted), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [26:0] op(input int b, input logic [1:0] rx, input logic [1:0] ry);
    logic [26:0] v;
    v = '0;
    v[b] = 1'b1;
    v[26:25] = rx;
    v[24:23] = ry;
    return v;
  endfunction

  task automatic cyc(input string nm, input logic [3:0] st, input logic [23:0] cw,
                     input logic d, input logic h, input logic e);
    exp_q.push_back({st, cw, d, h, e});
    name_q.push_back(nm);
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [30:0] ev, av;
      string nm;
      ev = exp_q.pop_front();
      nm = name_q.pop_front();
      av = {state_o, c, instr_done, halted, err};
      n_checks++;
      if (av !== ev) begin
        n_errors++;
        $display("FAIL %s: got st=%0d c=%h done=%b halt=%b err=%b, want st=%0d c=%h done=%b halt=%b err=%b",
                 nm, av[30:27], av[26:3], av[2], av[1], av[0],
                 ev[30:27], ev[26:3], ev[2], ev[1], ev[0]);
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; opcode_in = '0; flags = '0; mem_ready = 1'b1;
    @(posedge clock); #1;
    cyc("rst_hold", S_IF, 24'h0, 0, 1, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc("halt_idle", S_IF, 24'h0, 0, 1, 0);

    run = 1'b1; opcode_in = op(7, 2'd2, 2'd1);
    cyc("add_if", S_IF, C_IF, 0, 0, 0);
    cyc("add_id", S_ID, 24'h204C34, 0, 0, 0);
    cyc("add_ex", S_EXA, 24'hB02800, 0, 0, 0);
    cyc("add_wb", S_WBA, 24'h000300, 0, 0, 0);

    opcode_in = op(21, 2'd0, 2'd0); flags = 4'b0000;
    cyc("brg_if", S_IF, C_IF, 1, 0, 0);
    cyc("brg_t_id", S_ID, C_ID, 0, 0, 0);
    cyc("brg_t_jump", S_EXJ, 24'h000006, 0, 0, 0);
    flags = 4'b0001;
    cyc("brg_nt_if", S_IF, C_IF, 1, 0, 0);
    cyc("brg_nt_id", S_ID, C_ID, 0, 0, 0);

    opcode_in = op(11, 2'd1, 2'd3); mem_ready = 1'b0;
    cyc("load_if", S_IF, C_IF, 1, 0, 0);
    cyc("load_id", S_ID, 24'h204C6C, 0, 0, 0);
    cyc("load_ex", S_EXL, 24'hA42800, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("load_wait", S_MRD, 24'h400000, 0, 0, 0);
    mem_ready = 1'b1;
    cyc("load_rdy", S_MRD, 24'h400000, 0, 0, 0);
    cyc("load_wb", S_WBL, 24'h020280, 0, 0, 0);

    opcode_in = op(9, 2'd3, 2'd0);
    cyc("sub_if", S_IF, C_IF, 1, 0, 0);
    run = 1'b0;
    cyc("sub_id", S_ID, 24'h204C1C, 0, 0, 0);
    cyc("sub_ex", S_EXA, 24'hB03800, 0, 0, 0);
    cyc("sub_wb", S_WBA, 24'h000380, 0, 0, 0);
    cyc("sub_halt_done", S_IF, 24'h0, 1, 1, 0);
    cyc("sub_halt", S_IF, 24'h0, 0, 1, 0);

    run = 1'b1; opcode_in = op(14, 2'd0, 2'd0);
    cyc("storef_if", S_IF, C_IF, 0, 0, 0);
    cyc("storef_id", S_ID, C_ID, 0, 0, 0);
    cyc("storef_ex", S_EXD, 24'hA02800, 0, 0, 0);
    cyc("storef_mem", S_MWR, 24'h010000, 0, 0, 0);

    opcode_in = op(11, 2'd0, 2'd0); mem_ready = 1'b0;
    cyc("tmo_if", S_IF, C_IF, 1, 0, 0);
    cyc("tmo_id", S_ID, C_ID, 0, 0, 0);
    cyc("tmo_ex", S_EXL, 24'hA42800, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc("tmo_wait", S_MRD, 24'h400000, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("tmo_err", S_ERR, 24'h0, 0, 0, 1);
    mem_ready = 1'b1;
    reset = 1'b1;
    cyc("tmo_reset", S_IF, C_IF, 0, 0, 0);
    reset = 1'b0;

    opcode_in = '0;
    cyc("zero_if", S_IF, C_IF, 0, 0, 0);
    cyc("zero_id", S_ID, C_ID, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("zero_err", S_ERR, 24'h0, 0, 0, 1);
    reset = 1'b1;
    cyc("zero_reset", S_IF, C_IF, 0, 0, 0);
    reset = 1'b0;

    opcode_in = op(7, 2'd0, 2'd0) | op(9, 2'd0, 2'd0);
    cyc("two_if", S_IF, C_IF, 0, 0, 0);
    cyc("two_id", S_ID, C_ID, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("two_err", S_ERR, 24'h0, 0, 0, 1);
    reset = 1'b1;
    cyc("two_reset", S_IF, C_IF, 0, 0, 0);
    reset = 1'b0;

    opcode_in = op(13, 2'd0, 2'd0); mem_ready = 1'b0;
    cyc("store_if", S_IF, C_IF, 0, 0, 0);
    cyc("store_id", S_ID, C_ID, 0, 0, 0);
    cyc("store_ex", S_EXL, 24'hA42800, 0, 0, 0);
    cyc("store_mem", S_MWR, 24'h010000, 0, 0, 0);
    #1 reset = 1'b1;
    cyc("store_async_rst", S_IF, C_IF, 0, 0, 0);
    reset = 1'b0; mem_ready = 1'b1;
    cyc("post_rst_if", S_IF, C_IF, 0, 0, 0);
    cyc("post_rst_id", S_ID, C_ID, 0, 0, 0);

    @(negedge clock); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
